// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the packing/unpacking FIFO family.
package fifo_pkg;

    localparam int DEF_X     = 8;
    localparam int DEF_DEPTH = 4;

    // Level counts narrow halves, so it must hold values 0 .. 2*depth.
    function automatic int level_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port register-array storage: synchronous write, combinational read.
module fifo_mem_2p #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_unpack.sv
// Wide-to-narrow FIFO: stores 2*X-bit words, returns X-bit halves low first.
module fifo_unpack
    import fifo_pkg::*;
#(
    parameter int X     = DEF_X,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LW    = level_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr,
    input  logic [2*X-1:0] Wdata,
    input  logic           rd,
    output logic [X-1:0]   Rdata,
    output logic           rvalid,
    output logic           full,
    output logic           empty,
    output logic [LW-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           half_sel;
    logic           wr_en;
    logic           rd_en;
    logic           free_en;
    logic [2*X-1:0] rword;

    fifo_mem_2p #(
        .W     (2 * X),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (Wdata),
        .raddr (rptr),
        .rdata (rword)
    );

    // Flags come only from registered state, so a read cannot unblock a same-cycle write.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        full    = 1'b0;
        empty   = 1'b1;
        level   = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        free_en = 1'b0;

        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        level   = LW'({count, 1'b0}) - LW'(half_sel);
        wr_en   = wr && !full;
        rd_en   = rd && !empty;
        free_en = rd_en && half_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            half_sel <= 1'b0;
            Rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rvalid <= rd_en;
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                half_sel <= !half_sel;
                Rdata    <= half_sel ? rword[2*X-1:X] : rword[X-1:0];
            end
            if (free_en) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_en && !free_en) begin
                count <= count + 1'b1;
            end else if (!wr_en && free_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
